entry_capture_sequencer: RTL

- Front-end stage for the 2-bit magnitude comparator in the entry-comparison design.
- Captures two operands, A then B, from 2-bit slide switches on successive debounced presses of the enter button, and drives them to the comparator.
- Samples the comparator's AeqB/AgeqB/AltB outputs back into a result register.
- Flags illegal comparator codes and keeps saturating tallies of the outcomes.

---
 rtl/entry_capture_sequencer_if.sv | 34 +++
 rtl/entry_capture_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/entry_capture_sequencer_if.sv
// Bundles the switch/button inputs, comparator feedback and result outputs
// of the entry capture sequencer into one connection.
interface entry_capture_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       sw;
    logic             enter;
    logic             clear;
    logic             AeqB_in;
    logic             AgeqB_in;
    logic             AltB_in;
    logic [1:0]       A;
    logic [1:0]       B;
    logic [1:0]       state;
    logic             result_valid;
    logic             res_eq;
    logic             res_geq;
    logic             res_lt;
    logic             err;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] eq_count;

    modport slave (
        input  sw, enter, clear, AeqB_in, AgeqB_in, AltB_in,
        output A, B, state, result_valid, res_eq, res_geq, res_lt, err,
               lt_count, eq_count
    );

    modport master (
        output sw, enter, clear, AeqB_in, AgeqB_in, AltB_in,
        input  A, B, state, result_valid, res_eq, res_geq, res_lt, err,
               lt_count, eq_count
    );
endinterface

// File: rtl/entry_capture_sequencer.sv
// Captures operands A then B on debounced enter presses, feeds them to the
// 2-bit comparator and registers its verdict with error flag and tallies.
module entry_capture_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    entry_capture_sequencer_if.slave  bus
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE_A = 2'b00,
        WAIT_B = 2'b01,
        EVAL   = 2'b10,
        SHOW   = 2'b11
    } stateT;

    logic [1:0]       syncFf;
    logic [DEB_W-1:0] debCnt;
    logic             deb;
    logic             debPrev;
    logic             press;

    stateT            curState;
    logic [1:0]       aReg;
    logic [1:0]       bReg;
    logic             resultValid;
    logic             resEq;
    logic             resGeq;
    logic             resLt;
    logic             errFlag;
    logic [CNT_W-1:0] ltCount;
    logic [CNT_W-1:0] eqCount;

    logic [2:0]       cmpCode;
    logic             codeLegal;

    assign cmpCode   = {bus.AeqB_in, bus.AgeqB_in, bus.AltB_in};
    assign codeLegal = (cmpCode == 3'b110) || (cmpCode == 3'b010) || (cmpCode == 3'b001);

    // Button conditioning runs independently of clear so a held button is not re-detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncFf  <= '0;
            debCnt  <= '0;
            deb     <= 1'b0;
            debPrev <= 1'b0;
            press   <= 1'b0;
        end else begin
            syncFf  <= {syncFf[0], bus.enter};
            debPrev <= deb;
            press   <= deb & ~debPrev;
            if (syncFf[1] != deb) begin
                if (debCnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb    <= syncFf[1];
                    debCnt <= '0;
                end else begin
                    debCnt <= debCnt + 1'b1;
                end
            end else begin
                debCnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState    <= IDLE_A;
            aReg        <= '0;
            bReg        <= '0;
            resultValid <= 1'b0;
            resEq       <= 1'b0;
            resGeq      <= 1'b0;
            resLt       <= 1'b0;
            errFlag     <= 1'b0;
            ltCount     <= '0;
            eqCount     <= '0;
        end else if (bus.clear) begin
            curState    <= IDLE_A;
            aReg        <= '0;
            bReg        <= '0;
            resultValid <= 1'b0;
            resEq       <= 1'b0;
            resGeq      <= 1'b0;
            resLt       <= 1'b0;
            errFlag     <= 1'b0;
            ltCount     <= '0;
            eqCount     <= '0;
        end else begin
            resultValid <= 1'b0;
            case (curState)
                IDLE_A, SHOW: begin
                    if (press) begin
                        aReg     <= bus.sw;
                        curState <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (press) begin
                        bReg     <= bus.sw;
                        curState <= EVAL;
                    end
                end
                EVAL: begin
                    // Illegal codes are still shown, but only flagged rather than tallied.
                    {resEq, resGeq, resLt} <= cmpCode;
                    resultValid            <= 1'b1;
                    curState               <= SHOW;
                    if (!codeLegal) begin
                        errFlag <= 1'b1;
                    end else if (cmpCode == 3'b001) begin
                        if (ltCount != '1) ltCount <= ltCount + 1'b1;
                    end else if (cmpCode == 3'b110) begin
                        if (eqCount != '1) eqCount <= eqCount + 1'b1;
                    end
                end
                default: curState <= IDLE_A;
            endcase
        end
    end

    assign bus.A            = aReg;
    assign bus.B            = bReg;
    assign bus.state        = curState;
    assign bus.result_valid = resultValid;
    assign bus.res_eq       = resEq;
    assign bus.res_geq      = resGeq;
    assign bus.res_lt       = resLt;
    assign bus.err          = errFlag;
    assign bus.lt_count     = ltCount;
    assign bus.eq_count     = eqCount;
endmodule
